// File: rtl/alu_pkg.sv
// Shared ALU definitions: select codes used by the ALU control decoder and
// the execute stage, plus the default-width result entry type.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam int ALU_DATA_W = 32;
  localparam int ALU_TAG_W  = 5;

  // One result travelling towards EX/MEM at the default datapath width.
  typedef struct packed {
    logic [ALU_DATA_W-1:0] result;
    logic                  zero;
    logic                  ovf;
    logic                  ill;
    logic [ALU_TAG_W-1:0]  tag;
  } alu_entry_t;

endpackage

// File: rtl/alu_exec_stage_if.sv
// Execute-stage bus: operand/op handshake in, result/flags handshake out.
// Valid/ready rule on both sides: a transfer happens on a rising clk edge
// where valid and ready are both 1; the sender holds its payload stable
// while valid is high and ready is low, and ready never depends
// combinationally on valid.
interface alu_exec_stage_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_select;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             illegal_op;
  logic [TAG_W-1:0] tag_out;

  modport master (
    output in_valid, alu_select, op_a, op_b, tag_in, out_ready,
    input  in_ready, out_valid, result, zero, overflow, illegal_op, tag_out
  );

  modport slave (
    input  in_valid, alu_select, op_a, op_b, tag_in, out_ready,
    output in_ready, out_valid, result, zero, overflow, illegal_op, tag_out
  );
endinterface

// File: rtl/alu_core.sv
// Purely combinational ALU: result plus zero/overflow/illegal flags.
// SUB and SLT share one adder fed with the inverted B operand and a carry-in.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       alu_select,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal_op
);
  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic             add_ovf;

  assign is_sub  = (alu_select == ALU_SUB) || (alu_select == ALU_SLT);
  assign b_eff   = is_sub ? ~op_b : op_b;
  assign sum     = op_a + b_eff + {{(WIDTH-1){1'b0}}, is_sub};
  // Signed overflow: operands agree in sign but the sum does not.
  assign add_ovf = (op_a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);

  // Select the operation result and flags; unknown codes give a zero result.
  always_comb begin
    result     = '0;
    overflow   = 1'b0;
    illegal_op = 1'b0;
    case (alu_select)
      ALU_AND: result = op_a & op_b;
      ALU_OR:  result = op_a | op_b;
      ALU_ADD: begin
        result   = sum;
        overflow = add_ovf;
      end
      ALU_SUB: begin
        result   = sum;
        overflow = add_ovf;
      end
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
      default: illegal_op = 1'b1;
    endcase
  end

  assign zero = (result == '0);
endmodule

// File: rtl/alu_exec_stage.sv
// ALU execute stage: computes on acceptance, registers the result into a
// main entry that drives the outputs, and parks one extra result in a skid
// entry under back-pressure so nothing is dropped and order is kept.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  alu_exec_stage_if.slave  bus
);
  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             ovf;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t     main_q;
  entry_t     skid_q;
  logic       main_valid;
  logic       skid_valid;
  entry_t     new_entry;
  logic       accept;
  logic       pop;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .alu_select (bus.alu_select),
    .op_a       (bus.op_a),
    .op_b       (bus.op_b),
    .result     (new_entry.result),
    .zero       (new_entry.zero),
    .overflow   (new_entry.ovf),
    .illegal_op (new_entry.ill)
  );
  assign new_entry.tag = bus.tag_in;

  // Ready comes only from registered state and reset, never from out_ready.
  assign bus.in_ready = !skid_valid && !rst;
  assign accept       = bus.in_valid && bus.in_ready;
  assign pop          = main_valid && bus.out_ready;

  // Main/skid entry update: new data goes to main when it is free or
  // draining, otherwise to skid; a pop without new data refills from skid.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (accept) begin
      if (!main_valid || pop) begin
        main_q     <= new_entry;
        main_valid <= 1'b1;
      end else begin
        skid_q     <= new_entry;
        skid_valid <= 1'b1;
      end
    end else if (pop) begin
      if (skid_valid) begin
        main_q     <= skid_q;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= 1'b0;
      end
    end
  end

  assign bus.out_valid  = main_valid;
  assign bus.result     = main_q.result;
  assign bus.zero       = main_q.zero;
  assign bus.overflow   = main_q.ovf;
  assign bus.illegal_op = main_q.ill;
  assign bus.tag_out    = main_q.tag;
endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: directed scenarios with literal expectations,
// then randomized traffic checked against an arithmetic reference model
// through an expected queue.
module tb_alu_exec_stage;
  import alu_pkg::*;

  localparam int W  = 32;
  localparam int TW = 5;
  localparam int EW = W + 3 + TW;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [EW-1:0] exp_q[$];

  alu_exec_stage_if #(.WIDTH(W), .TAG_W(TW)) bus ();

  alu_exec_stage #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: plain signed arithmetic, packed as {result, zero, ovf, ill, tag}.
  function automatic logic [EW-1:0] model(input logic [3:0] sel, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic [TW-1:0] t);
    longint sa;
    longint sb;
    longint r;
    logic [W-1:0] res;
    logic o;
    logic il;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    r   = 0;
    res = '0;
    o   = 1'b0;
    il  = 1'b0;
    case (sel)
      ALU_AND: res = a & b;
      ALU_OR:  res = a | b;
      ALU_ADD: begin
        r   = sa + sb;
        res = r[W-1:0];
        o   = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      ALU_SUB: begin
        r   = sa - sb;
        res = r[W-1:0];
        o   = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      ALU_SLT: res = (sa < sb) ? 32'd1 : 32'd0;
      default: il = 1'b1;
    endcase
    return {res, (res == '0), o, il, t};
  endfunction

  // Per-cycle monitor at the negedge: occupancy, head-of-queue payload, accepts.
  task automatic monitor();
    logic [EW-1:0] got;
    check("in_ready", bus.in_ready, (exp_q.size() < 2));
    check("out_valid", bus.out_valid, (exp_q.size() > 0));
    if (bus.out_valid && exp_q.size() > 0) begin
      got = {bus.result, bus.zero, bus.overflow, bus.illegal_op, bus.tag_out};
      check("entry", got, exp_q[0]);
      if (bus.out_ready) void'(exp_q.pop_front());
    end
    if (bus.in_valid && bus.in_ready)
      exp_q.push_back(model(bus.alu_select, bus.op_a, bus.op_b, bus.tag_in));
  endtask

  // Driver: apply inputs for one cycle; returns #1 after the next rising edge.
  task automatic step(input logic v, input logic [3:0] sel, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [TW-1:0] t, input logic ordy);
    bus.in_valid   = v;
    bus.alu_select = sel;
    bus.op_a       = a;
    bus.op_b       = b;
    bus.tag_in     = t;
    bus.out_ready  = ordy;
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [W-1:0] res, input logic z,
                            input logic o, input logic il, input logic [TW-1:0] t);
    check({tag, "_valid"}, bus.out_valid, 1'b1);
    check({tag, "_result"}, bus.result, res);
    check({tag, "_zero"}, bus.zero, z);
    check({tag, "_ovf"}, bus.overflow, o);
    check({tag, "_ill"}, bus.illegal_op, il);
    check({tag, "_tag"}, bus.tag_out, t);
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && exp_q.size() > 0; i++) step(1'b0, ALU_AND, '0, '0, '0, 1'b1);
    check("drain_empty", exp_q.size(), 0);
  endtask

  // Stimulus
  initial begin
    logic [3:0]   sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   codes [6];
    checks = 0;
    errors = 0;
    codes[0] = ALU_AND; codes[1] = ALU_OR; codes[2] = ALU_ADD;
    codes[3] = ALU_SUB; codes[4] = ALU_SLT; codes[5] = 4'b1111;

    // Reset held 3 cycles with in_valid high.
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.alu_select = ALU_ADD; bus.op_a = 32'd7; bus.op_b = 32'd9;
    bus.tag_in = 5'd1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_in_ready", bus.in_ready, 1'b0);
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_outputs", {bus.result, bus.zero, bus.overflow, bus.illegal_op, bus.tag_out}, '0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();

    // ADD overflow.
    step(1'b1, ALU_ADD, 32'h7FFF_FFFF, 32'h1, 5'd3, 1'b1);
    expect_out("add_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0, 5'd3);

    // SUB then SLT back to back.
    step(1'b1, ALU_SUB, 32'd5, 32'd5, 5'd4, 1'b1);
    expect_out("sub_zero", 32'h0, 1'b1, 1'b0, 1'b0, 5'd4);
    step(1'b1, ALU_SLT, 32'hFFFF_FFFF, 32'd1, 5'd5, 1'b1);
    expect_out("slt_neg", 32'h1, 1'b0, 1'b0, 1'b0, 5'd5);
    drain();

    // Back-pressure: two results held, input stalls, then drained in order.
    step(1'b1, ALU_AND, 32'hF0F0, 32'hFF00, 5'd6, 1'b0);
    step(1'b1, ALU_OR, 32'h0F, 32'hF0, 5'd7, 1'b0);
    check("bp_in_ready", bus.in_ready, 1'b0);
    expect_out("bp_first", 32'hF000, 1'b0, 1'b0, 1'b0, 5'd6);
    step(1'b0, ALU_AND, '0, '0, '0, 1'b0);
    expect_out("bp_hold", 32'hF000, 1'b0, 1'b0, 1'b0, 5'd6);
    step(1'b0, ALU_AND, '0, '0, '0, 1'b1);
    expect_out("bp_second", 32'hFF, 1'b0, 1'b0, 1'b0, 5'd7);
    check("bp_ready_back", bus.in_ready, 1'b1);
    drain();

    // Illegal select.
    step(1'b1, 4'b1111, 32'h123, 32'h456, 5'd9, 1'b1);
    expect_out("illegal", 32'h0, 1'b1, 1'b0, 1'b1, 5'd9);
    drain();

    // Reset with both entries full.
    step(1'b1, ALU_ADD, 32'd1, 32'd2, 5'd10, 1'b0);
    step(1'b1, ALU_ADD, 32'd3, 32'd4, 5'd11, 1'b0);
    check("full_in_ready", bus.in_ready, 1'b0);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("midrst_out_valid", bus.out_valid, 1'b0);
    check("midrst_in_ready", bus.in_ready, 1'b0);
    rst = 1'b0;
    exp_q.delete();
    step(1'b1, ALU_ADD, 32'd10, 32'd20, 5'd2, 1'b1);
    expect_out("post_rst", 32'd30, 1'b0, 1'b0, 1'b0, 5'd2);
    drain();

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      sel = codes[$urandom_range(0, 5)];
      case ($urandom_range(0, 3))
        0: a = 32'h7FFF_FFFF;
        1: a = 32'h8000_0000;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0: b = 32'hFFFF_FFFF;
        1: b = a;
        default: b = $urandom;
      endcase
      step(($urandom_range(0, 3) != 0), sel, a, b, TW'($urandom), ($urandom_range(0, 2) != 0));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
